// File: rtl/bram_sp_arbiter_if.sv
// rtl/bram_sp_arbiter_if.sv - valid/ready requester port shared by both masters
interface bram_sp_arbiter_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, output addr, output wdata, output wstrb,
                    input  ready, input  rdata);
    modport slave  (input  valid, input  addr, input  wdata, input  wstrb,
                    output ready, output rdata);
endinterface

// File: rtl/bram_sp_arbiter.sv
// rtl/bram_sp_arbiter.sv - round-robin two-port arbiter in front of a single-port BRAM
module bram_sp_arbiter #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_sp_arbiter_if.slave      m0,
    bram_sp_arbiter_if.slave      m1,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    output logic [31:0]           bram_din_o,
    output logic [3:0]            bram_we_o,
    input  logic [31:0]           bram_dout_i,
    output logic                  busy_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [31:0]           bram_din_q, bram_din_d;
    logic [3:0]            bram_we_q, bram_we_d;
    logic                  rdy0_q, rdy0_d;
    logic                  rdy1_q, rdy1_d;
    logic                  gnt_q, gnt_d;
    logic                  rr_last_q, rr_last_d;

    logic                  sel;
    logic [31:0]           sel_addr;

    // Byte offset and bits beyond the BRAM depth are deliberately dropped.
    logic unused_bits;
    assign unused_bits = ^{m0.addr[31:ADDR_WIDTH+2], m0.addr[1:0],
                           m1.addr[31:ADDR_WIDTH+2], m1.addr[1:0]};

    // Pick the requester: a lone valid wins, a tie goes to the port not served last.
    always_comb begin
        sel = 1'b0;
        if (m0.valid && m1.valid) begin
            sel = ~rr_last_q;
        end else if (m1.valid) begin
            sel = 1'b1;
        end
        sel_addr = sel ? m1.addr : m0.addr;
    end

    // Next-state and registered-output logic for the one-access-at-a-time sequencer.
    always_comb begin
        state_d     = state_q;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        bram_we_d   = bram_we_q;
        rdy0_d      = rdy0_q;
        rdy1_d      = rdy1_q;
        gnt_d       = gnt_q;
        rr_last_d   = rr_last_q;
        case (state_q)
            IDLE: begin
                if (m0.valid || m1.valid) begin
                    bram_addr_d = sel_addr[ADDR_WIDTH+1:2];
                    bram_din_d  = sel ? m1.wdata : m0.wdata;
                    bram_we_d   = sel ? m1.wstrb : m0.wstrb;
                    gnt_d       = sel;
                    rr_last_d   = sel;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // BRAM captures the access at the end of this cycle; one write edge only.
                bram_we_d = 4'h0;
                rdy0_d    = ~gnt_q;
                rdy1_d    = gnt_q;
                state_d   = DONE;
            end
            DONE: begin
                rdy0_d  = 1'b0;
                rdy1_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and BRAM-side registers; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            bram_we_q   <= 4'h0;
            rdy0_q      <= 1'b0;
            rdy1_q      <= 1'b0;
            gnt_q       <= 1'b0;
            rr_last_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            bram_we_q   <= bram_we_d;
            rdy0_q      <= rdy0_d;
            rdy1_q      <= rdy1_d;
            gnt_q       <= gnt_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign bram_addr_o = bram_addr_q;
    assign bram_din_o  = bram_din_q;
    assign bram_we_o   = bram_we_q;
    assign busy_o      = (state_q != IDLE);
    assign m0.ready    = rdy0_q;
    assign m1.ready    = rdy1_q;
    assign m0.rdata    = bram_dout_i;
    assign m1.rdata    = bram_dout_i;
endmodule

// File: tb/tb_bram_sp_arbiter.sv
// tb/tb_bram_sp_arbiter.sv - self-checking bench for bram_sp_arbiter
module tb_bram_sp_arbiter;
    localparam int AW = 8;

    logic          clk;
    logic          rst;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_din;
    logic [3:0]    bram_we;
    logic [31:0]   bram_dout;
    logic          busy;

    bram_sp_arbiter_if m0_if ();
    bram_sp_arbiter_if m1_if ();

    bram_sp_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0         (m0_if),
        .m1         (m1_if),
        .bram_addr_o(bram_addr),
        .bram_din_o (bram_din),
        .bram_we_o  (bram_we),
        .bram_dout_i(bram_dout),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM with registered read-first output and a preload port for setup.
    logic [31:0]   mem [2**AW];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [31:0]   pl_data;
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
        end
        bram_dout <= mem[bram_addr];
    end

    // Reference model: word array updated by byte-merging each completed write.
    logic [31:0] ref_mem [2**AW];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (p == 0) begin
            m0_if.valid = v; m0_if.addr = a; m0_if.wdata = d; m0_if.wstrb = s;
        end else begin
            m1_if.valid = v; m1_if.addr = a; m1_if.wdata = d; m1_if.wstrb = s;
        end
    endtask

    // One access from port p; called just after a rising edge, returns just after one.
    task automatic do_access(input int p, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] rd, output int lat,
                             output logic [AW-1:0] iss_addr, output logic [3:0] iss_we,
                             output logic other_seen);
        logic mine, other;
        rd = '0; lat = -1; iss_addr = '0; iss_we = '0; other_seen = 1'b0;
        drive(p, 1'b1, a, d, s);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            mine  = (p == 0) ? m0_if.ready : m1_if.ready;
            other = (p == 0) ? m1_if.ready : m0_if.ready;
            if (c == 1) begin iss_addr = bram_addr; iss_we = bram_we; end
            if (other) other_seen = 1'b1;
            if (mine) begin
                lat = c;
                rd  = (p == 0) ? m0_if.rdata : m1_if.rdata;
                break;
            end
        end
        @(posedge clk); #1;
        drive(p, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Full checked access against the reference model, optional fixed expectation.
    task automatic run_access(input string tag, input int p, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic use_exp, input logic [31:0] exp_rd);
        logic [31:0]   rd;
        int            lat;
        logic [AW-1:0] ia;
        logic [3:0]    iw;
        logic          oth;
        logic [AW-1:0] w;
        w = a[AW+1:2];
        do_access(p, a, d, s, rd, lat, ia, iw, oth);
        check({tag, "_latency"}, 64'(lat), 64'd2);
        check({tag, "_issue_addr"}, 64'(ia), 64'(w));
        check({tag, "_issue_we"}, 64'(iw), 64'(s));
        check({tag, "_other_ready"}, 64'(oth), 64'd0);
        if (s == 4'h0) begin
            check({tag, "_rdata"}, 64'(rd), 64'(use_exp ? exp_rd : ref_mem[w]));
        end else begin
            ref_mem[w] = merge(ref_mem[w], d, s);
        end
    endtask

    typedef struct {
        int          port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          ord [8];
        int          tim [8];
        logic [31:0] rdv [8];
        int          k, n0, n1;
        logic        both;

        vecs[0] = '{0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
        vecs[1] = '{0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
        vecs[2] = '{1, 32'h0000_0030, 32'h0000_00AA, 4'h1, 32'h0};
        vecs[3] = '{0, 32'h0000_0030, 32'h0,         4'h0, 32'h1122_33AA};
        vecs[4] = '{0, 32'h0000_0400, 32'h0000_0055, 4'hF, 32'h0};
        vecs[5] = '{0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0055};
        vecs[6] = '{1, 32'hF000_03FF, 32'hA5C3_0000, 4'hC, 32'h0};
        vecs[7] = '{1, 32'h0000_03FC, 32'h0,         4'h0, 32'hA5C3_0000};

        rst = 1'b1;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 2**AW; i++) begin
            pl_en   = 1'b1;
            pl_addr = AW'(i);
            pl_data = (i == 12) ? 32'h1122_3344 : 32'h0;
            ref_mem[i] = pl_data;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;

        @(negedge clk);
        check("reset_m0_ready", 64'(m0_if.ready), 64'd0);
        check("reset_m1_ready", 64'(m1_if.ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_bram_we", 64'(bram_we), 64'd0);
        check("reset_bram_addr", 64'(bram_addr), 64'd0);
        check("reset_bram_din", 64'(bram_din), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_access($sformatf("vec%0d", i), vecs[i].port, vecs[i].addr, vecs[i].wdata,
                       vecs[i].wstrb, 1'b1, vecs[i].exp_rdata);

        // Reset lands while a port 1 write sits in ISSUE.
        drive(1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("rstissue_we_before", 64'(bram_we), 64'hF);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstissue_m1_ready", 64'(m1_if.ready), 64'd0);
        check("rstissue_busy", 64'(busy), 64'd0);
        check("rstissue_we", 64'(bram_we), 64'd0);
        @(negedge clk);
        check("rstissue_m1_ready_late", 64'(m1_if.ready), 64'd0);
        ref_mem[8] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        run_access("rstissue_readback", 0, 32'h0000_0020, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D);

        // Reset, then both ports request together and keep contending.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b1, 32'h0000_0000, 32'h0, 4'h0);
        drive(1, 1'b1, 32'h0000_0004, 32'h0, 4'h0);
        k = 0; n0 = 0; n1 = 0; both = 1'b0;
        for (int c = 0; c < 60 && (n0 < 4 || n1 < 4); c++) begin
            @(negedge clk);
            if (m0_if.ready && m1_if.ready) both = 1'b1;
            if (m0_if.ready && k < 8) begin
                ord[k] = 0; tim[k] = c; rdv[k] = m0_if.rdata; k++; n0++;
            end else if (m1_if.ready && k < 8) begin
                ord[k] = 1; tim[k] = c; rdv[k] = m1_if.rdata; k++; n1++;
            end
            @(posedge clk); #1;
            if (n0 >= 4) drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
            if (n1 >= 4) drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        end
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        check("rr_count", 64'(k), 64'd8);
        check("rr_port0_pulses", 64'(n0), 64'd4);
        check("rr_port1_pulses", 64'(n1), 64'd4);
        check("rr_simultaneous_ready", 64'(both), 64'd0);
        for (int i = 0; i < k; i++) begin
            check($sformatf("rr_order%0d", i), 64'(ord[i]), 64'(i % 2));
            check($sformatf("rr_rdata%0d", i), 64'(rdv[i]), 64'(ref_mem[i % 2]));
            if (i == 0) check("rr_first_time", 64'(tim[0]), 64'd2);
            else check($sformatf("rr_spacing%0d", i), 64'(tim[i] - tim[i-1]), 64'd3);
        end
        @(posedge clk); #1;

        // Randomized single-port traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            int          p;
            logic [31:0] a;
            logic [3:0]  s;
            p = int'($urandom_range(0, 1));
            a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            run_access($sformatf("rand%0d", i), p, a, $urandom, s, 1'b0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_sp_arbiter.md
Name: bram_sp_arbiter

Overview:
Two-requester controller that shares one single-port 32-bit instruction/data BRAM between requesters using picorv32-style valid/ready handshakes. Port 0 is the CPU memory bus; port 1 is a secondary master (firmware loader / debug). Round-robin arbitration sequences one BRAM access at a time and drives the BRAM address, write data and byte enables from registers. Read data comes from the BRAM's registered output.

Parameters:
ADDR_WIDTH, 8, BRAM word-address width; BRAM depth is 2**ADDR_WIDTH 32-bit words.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
m0_valid  in  1  port 0 request; held high until m0_ready
m0_addr  in  32  port 0 byte address
m0_wdata  in  32  port 0 write data
m0_wstrb  in  4  port 0 byte strobes; 0 = read
m0_ready  out  1  port 0 one-cycle completion pulse
m0_rdata  out  32  port 0 read data; valid only while m0_ready=1
m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as port 0, for port 1
bram_addr  out  ADDR_WIDTH  BRAM word address
bram_din  out  32  BRAM write data
bram_we  out  4  BRAM byte write enables
bram_dout  in  32  BRAM registered read data; one-cycle read latency
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: state=IDLE, bram_addr=0, bram_din=0, bram_we=0, m0_ready=0, m1_ready=0, busy=0, rr_last=1 (port 0 wins the first tie).
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - No valid: stay in IDLE.
  - Exactly one valid: grant that port.
  - Both valid: grant the port not equal to rr_last.
  - On grant: register bram_addr = addr[ADDR_WIDTH+1:2], bram_din = wdata, bram_we = wstrb. Latch gnt and set rr_last = gnt. Go to ISSUE.
- ISSUE: the BRAM samples bram_addr/bram_din/bram_we at the end of this cycle. Clear bram_we to 0 for the next cycle. Set the granted port's ready register. Go to DONE.
- DONE:
  - The granted port's ready is high for exactly this cycle.
  - Both mN_rdata outputs are wired to bram_dout. For a read they carry mem[addr] in this cycle.
  - For writes, rdata is don't-care. The read-during-write value is whatever the BRAM returns.
  - Clear ready. Go to IDLE.
- Latency: valid sampled high in IDLE at cycle 0 gives ready in cycle 2. Minimum 3 cycles per access. Back-to-back requests from one port are accepted every 3 cycles.
- bram_we is non-zero only during ISSUE, so each access produces exactly one write edge. Byte strobes pass through unmodified.
- Address bits [1:0] and bits above ADDR_WIDTH+1 are ignored. Out-of-range addresses wrap modulo the BRAM depth.
- Requests are not preempted. A valid arriving on the other port during ISSUE/DONE is held off (ready=0) until the next IDLE.
- Fairness: under continuous contention, grants alternate 0,1,0,1. A single active port is granted back-to-back with no idle penalty beyond the 3-cycle access.
- If a requester drops valid mid-transaction (protocol violation), the access still completes and the ready pulse is still issued.
- Reset mid-operation:
  - A write already registered in ISSUE is committed by the BRAM at the reset edge, because the BRAM samples the pre-reset bram_we.
  - No ready is issued. The FSM returns to IDLE.
  - The requester must re-issue.
- rst has priority over all transitions.

Test Plan:
- Port 0 writes 0xDEADBEEF, wstrb=4'hF, to addr 0x10, then reads 0x10. Required: m0_ready in cycle 2 of each request; read returns 0xDEADBEEF; m1_ready stays 0.
- Port 1 writes 0x000000AA with wstrb=4'b0001 to a word preloaded with 0x11223344, then port 0 reads it. Required: read returns 0x112233AA.
- Both ports hold valid for reads of 0x0 and 0x4 for 8 transactions. Required: grant order 0,1,0,1,...; each port gets 4 ready pulses; each ready arrives exactly 3 cycles after the previous ready.
- With ADDR_WIDTH=8, port 0 writes 0x55 to byte address 0x400. Required: bram_addr=0 during ISSUE; a subsequent read of address 0x0 returns 0x55.
- Assert rst during ISSUE of a port 1 write of 0xCAFEF00D to 0x20. Required: no m1_ready; next cycle state=IDLE, bram_we=0, busy=0; a later read of 0x20 returns 0xCAFEF00D.
- Assert rst, then raise m0_valid and m1_valid on the same cycle. Required: port 0 is granted first.
